// File: rtl/bram_portb_arbiter_pkg.sv
// Shared definitions for the BRAM port-B arbiter: FSM state encoding,
// requester identifiers and default widths matching the BRAM instance.
package bram_portb_arbiter_pkg;

   // Arbiter state; the encoding is also exported on the owner debug port
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   // Requester identifiers, also used as the read-return tag
   localparam logic REQ_VGA  = 1'b0;
   localparam logic REQ_LOAD = 1'b1;

   // Defaults matching the BRAM port-B geometry
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_BURST_LEN = 8;

   // Beat counter width; covers the full legal BURST_LEN range (1..255)
   localparam int BEAT_CNT_W = 8;

   // Ownership state that belongs to a given requester
   function automatic state_e own_state(input logic req);
      return req ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/bram_portb_arbiter_rd_return_tracker.sv
// Read-return tracker: remembers which requester issued each accepted
// read and steers the BRAM read data back to it LATENCY cycles later.
// The tag travels in a register chain, so ownership changes after the
// request was accepted never disturb the return.
module rd_return_tracker
   import bram_portb_arbiter_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_accept,
   input  logic              rd_tag,
   input  logic [DATA_W-1:0] q_b,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata
);

   logic [LATENCY-1:0] rd_pend_q, rd_pend_d;
   logic [LATENCY-1:0] rd_tag_q, rd_tag_d;

   // Shift the pending flag and its tag one step per cycle
   always_comb begin
      rd_pend_d    = rd_pend_q << 1;
      rd_tag_d     = rd_tag_q << 1;
      rd_pend_d[0] = rd_accept;
      rd_tag_d[0]  = rd_tag;
   end

   // Pending-read registers; reset drops any read still in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_q <= '0;
         rd_tag_q  <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_tag_q  <= rd_tag_d;
      end
   end

   // Demux the return: rvalid goes to the tagged requester, data is q_b as-is
   always_comb begin
      r0_rvalid = rd_pend_q[LATENCY-1] && (rd_tag_q[LATENCY-1] == REQ_VGA);
      r1_rvalid = rd_pend_q[LATENCY-1] && (rd_tag_q[LATENCY-1] == REQ_LOAD);
      r0_rdata  = q_b;
      r1_rdata  = q_b;
   end

endmodule

// File: rtl/bram_portb_arbiter.sv
// BRAM port-B arbiter between the VGA scan-out reader (requester 0,
// read-only) and the program/debug loader (requester 1, read/write).
// Round-robin with bounded bursts: an owner keeps the port while it has
// valid requests, but yields after BURST_LEN accepted beats if the other
// requester is waiting. Read data is returned to the issuing requester.
// Optional build macro VGA_PRIORITY_EN gives requester 0 strict priority.
module bram_portb_arbiter
   import bram_portb_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [ADDR_W-1:0] r0_addr,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b,
   output logic [1:0]        owner
);

   // Last beat index of a burst; the counter saturates here
   localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = BEAT_CNT_W'(BURST_LEN - 1);

   state_e                  state_q, state_d;
   logic                    last_served_q, last_served_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0]       addr_hold_q, addr_hold_d;

   logic                    own_id;
   logic                    own_valid;
   logic                    oth_valid;
   logic                    exit_own;
   logic                    rd_accept;
   logic                    rd_tag;

   // Handshake and BRAM drive, straight from the owning requester's fields
   always_comb begin
      r0_ready = (state_q == OWN0);
      r1_ready = (state_q == OWN1);
      addr_b   = addr_hold_q;
      data_b   = '0;
      we_b     = 1'b0;
      case (state_q)
         OWN0: begin
            addr_b = r0_addr;
         end
         OWN1: begin
            addr_b = r1_addr;
            data_b = r1_wdata;
            we_b   = r1_we && r1_valid;
         end
         default: begin
         end
      endcase
      // In IDLE addr_b is the held value itself, so the hold is stable
      addr_hold_d = addr_b;
      rd_accept   = (r0_ready && r0_valid) || (r1_ready && r1_valid && !r1_we);
      rd_tag      = r1_ready ? REQ_LOAD : REQ_VGA;
      owner       = state_q;
   end

   // Ownership decisions: grant from IDLE, hold, yield or release
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      beat_cnt_d    = beat_cnt_q;
      exit_own      = 1'b0;
      own_id        = (state_q == OWN1);
      own_valid     = own_id ? r1_valid : r0_valid;
      oth_valid     = own_id ? r0_valid : r1_valid;

      case (state_q)
         IDLE: begin
            if (r0_valid && r1_valid) begin
`ifdef VGA_PRIORITY_EN
               state_d = OWN0;
`else
               state_d = own_state(~last_served_q);
`endif
            end else if (r0_valid) begin
               state_d = OWN0;
            end else if (r1_valid) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (!own_valid) begin
               // Owner went quiet: hand over or fall back to IDLE
               exit_own = 1'b1;
               state_d  = oth_valid ? own_state(~own_id) : IDLE;
            end else begin
`ifdef VGA_PRIORITY_EN
               // VGA preempts the loader after its current beat
               if (own_id == REQ_LOAD && r0_valid) begin
                  exit_own = 1'b1;
                  state_d  = OWN0;
               end else if (beat_cnt_q != BEAT_MAX) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
`else
               // Last beat of the burst with the other side waiting: hand over
               if (beat_cnt_q == BEAT_MAX && oth_valid) begin
                  exit_own = 1'b1;
                  state_d  = own_state(~own_id);
               end else if (beat_cnt_q != BEAT_MAX) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
`endif
            end
            if (exit_own) begin
               last_served_d = own_id;
               beat_cnt_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state registers; reset favours requester 0 on the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         last_served_q <= REQ_LOAD;
         beat_cnt_q    <= '0;
         addr_hold_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         beat_cnt_q    <= beat_cnt_d;
         addr_hold_q   <= addr_hold_d;
      end
   end

   rd_return_tracker #(
      .DATA_W  (DATA_W),
      .LATENCY (1)
   ) u_rd_return (
      .clk       (clk),
      .rst       (rst),
      .rd_accept (rd_accept),
      .rd_tag    (rd_tag),
      .q_b       (q_b),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata)
   );

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Self-checking bench for bram_portb_arbiter: a BRAM model on port B,
// directed scenarios and a randomized run against a reference model.
module tb_bram_portb_arbiter;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int BURST_LEN = 8;
`ifdef VGA_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              r0_valid;
   logic              r0_ready;
   logic [ADDR_W-1:0] r0_addr;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;
   logic              r1_valid;
   logic              r1_ready;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_b;
   logic              we_b;
   logic [DATA_W-1:0] q_b;
   logic [1:0]        owner;

   bram_portb_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_addr   (r0_addr),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .addr_b    (addr_b),
      .data_b    (data_b),
      .we_b      (we_b),
      .q_b       (q_b),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-up BRAM contents; 0x0010 holds 0xBEEF
   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h10) return 16'hBEEF;
      return {a, ~a} ^ 16'h3C5A;
   endfunction

   // BRAM port B: registered read, one-cycle latency
   logic [15:0]  bram [256];
   logic [255:0] bram_wr;
   logic         mem_clr;
   always @(posedge clk) begin
      if (mem_clr) bram_wr <= '0;
      else if (we_b) begin
         bram[addr_b[7:0]]    <= data_b;
         bram_wr[addr_b[7:0]] <= 1'b1;
      end
      q_b <= bram_wr[addr_b[7:0]] ? bram[addr_b[7:0]] : init_val(addr_b[7:0]);
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: who owns the port, how many beats this tenure has
   // taken, the model memory and the read result due this cycle
   int          m_state;
   int          m_last;
   int          m_served;
   int          m_rtag;
   logic        m_rv;
   logic [15:0] m_rdata;
   logic [15:0] m_addr_hold;
   logic [15:0] mmem [256];
   logic        mwr  [256];

   int          obs_owner;
   logic        obs_r0_rv;
   logic        obs_r1_rv;
   logic [15:0] obs_r1_rdata;
   logic        obs_we;

   function automatic logic [15:0] m_read(input logic [7:0] a);
      return mwr[a] ? mmem[a] : init_val(a);
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_last      = 1;
      m_served    = 0;
      m_rv        = 1'b0;
      m_rtag      = 0;
      m_rdata     = '0;
      m_addr_hold = '0;
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model
   task automatic step(input logic v0, input logic [15:0] a0, input logic v1,
                       input logic we1, input logic [15:0] a1, input logic [15:0] wd1);
      int          g;
      int          nxt;
      int          ntag;
      logic        acc;
      logic        nrv;
      logic        mine;
      logic        other;
      logic [15:0] ndata;
      logic [15:0] ea;
      logic [15:0] ed;
      logic        ew;
      r0_valid = v0;
      r0_addr  = a0;
      r1_valid = v1;
      r1_we    = we1;
      r1_addr  = a1;
      r1_wdata = wd1;
      @(negedge clk);
      obs_owner    = int'(owner);
      obs_r0_rv    = r0_rvalid;
      obs_r1_rv    = r1_rvalid;
      obs_r1_rdata = r1_rdata;
      obs_we       = we_b;
      ea = (m_state == 1) ? a0 : (m_state == 2) ? a1 : m_addr_hold;
      ed = (m_state == 2) ? wd1 : 16'h0000;
      ew = (m_state == 2) && v1 && we1;
      chk("owner", 32'(owner), 32'(m_state));
      chk("r0_ready", 32'(r0_ready), 32'(m_state == 1));
      chk("r1_ready", 32'(r1_ready), 32'(m_state == 2));
      chk("we_b", 32'(we_b), 32'(ew));
      chk("addr_b", 32'(addr_b), 32'(ea));
      chk("data_b", 32'(data_b), 32'(ed));
      chk("r0_rvalid", 32'(r0_rvalid), 32'(m_rv && m_rtag == 0));
      chk("r1_rvalid", 32'(r1_rvalid), 32'(m_rv && m_rtag == 1));
      if (m_rv) chk("rdata", 32'((m_rtag == 0) ? r0_rdata : r1_rdata), 32'(m_rdata));

      g     = m_state - 1;
      acc   = (g == 0 && v0) || (g == 1 && v1);
      nrv   = 1'b0;
      ntag  = 0;
      ndata = '0;
      if (acc) begin
         if (g == 0 || !we1) begin
            nrv   = 1'b1;
            ntag  = g;
            ndata = m_read((g == 0) ? a0[7:0] : a1[7:0]);
         end else begin
            mmem[a1[7:0]] = wd1;
            mwr[a1[7:0]]  = 1'b1;
         end
      end
      if (m_state != 0) m_addr_hold = ea;
      nxt = m_state;
      if (m_state == 0) begin
         if (v0 && v1) nxt = PRIO ? 1 : ((m_last == 1) ? 1 : 2);
         else if (v0) nxt = 1;
         else if (v1) nxt = 2;
      end else begin
         mine  = (g == 0) ? v0 : v1;
         other = (g == 0) ? v1 : v0;
         if (!mine) nxt = other ? ((g == 0) ? 2 : 1) : 0;
         else begin
            m_served++;
            if (PRIO) begin
               if (g == 1 && v0) nxt = 1;
            end else if (other && m_served >= BURST_LEN) begin
               nxt = (g == 0) ? 2 : 1;
            end
         end
         if (nxt != m_state) begin
            m_last   = g;
            m_served = 0;
         end
      end
      m_state = nxt;
      m_rv    = nrv;
      m_rtag  = ntag;
      m_rdata = ndata;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle: everything drops at once
   task automatic mid_reset();
      rst = 1'b0;
      #1;
      chk("mrst_owner", 32'(owner), 32'd0);
      chk("mrst_r0_ready", 32'(r0_ready), 32'd0);
      chk("mrst_r1_ready", 32'(r1_ready), 32'd0);
      chk("mrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("mrst_r1_rvalid", 32'(r1_rvalid), 32'd0);
      chk("mrst_we_b", 32'(we_b), 32'd0);
      chk("mrst_addr_b", 32'(addr_b), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic        rv0;
   logic        rv1;
   logic        rwe;
   logic [15:0] ra0;
   logic [15:0] ra1;
   logic [15:0] rwd;

   initial begin
      mem_clr  = 1'b1;
      rst      = 1'b0;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      r0_addr  = '0;
      r1_addr  = '0;
      r1_we    = 1'b0;
      r1_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         mwr[i]  = 1'b0;
         mmem[i] = '0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_r0_ready", 32'(r0_ready), 32'd0);
      chk("rst_r1_ready", 32'(r1_ready), 32'd0);
      chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
      chk("rst_we_b", 32'(we_b), 32'd0);
      chk("rst_addr_b", 32'(addr_b), 32'd0);
      chk("rst_data_b", 32'(data_b), 32'd0);
      rst = 1'b1;

      // Both valid out of reset: requester 0 owns one cycle later
      step(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0101, 16'h0);
      step(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0101, 16'h0);
      chk("rst_grant_owner", 32'(obs_owner), 32'd1);
      repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Single loader read of the preloaded word
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("single_rd_rvalid", 32'(obs_r1_rv), 32'd1);
      chk("single_rd_data", 32'(obs_r1_rdata), 32'hBEEF);
      chk("single_rd_r0_rvalid", 32'(obs_r0_rv), 32'd0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Loader write then read back
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234);
      step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234);
      chk("wr_we_b", 32'(obs_we), 32'd1);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
      chk("wr_no_rvalid", 32'(obs_r1_rv), 32'd0);
      chk("rd_we_b", 32'(obs_we), 32'd0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("wr_rd_rvalid", 32'(obs_r1_rv), 32'd1);
      chk("wr_rd_data", 32'(obs_r1_rdata), 32'h1234);
      step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Both continuously valid: alternating bursts, requester 0 first
      step(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 16'h0);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < BURST_LEN; j++) begin
            step(1'b1, 16'(16'h0030 + j), 1'b1, j[0], 16'(16'h0040 + j), 16'(16'hA000 + j));
            chk("fair_owner", 32'(obs_owner), PRIO ? 32'd1 : ((k % 2 == 0) ? 32'd1 : 32'd2));
         end
      end
      repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Requester 0 drops valid after three beats while the loader waits
      step(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0060, 16'h0);
      for (int j = 0; j < 3; j++) step(1'b1, 16'(16'h0050 + j), 1'b1, 1'b0, 16'h0060, 16'h0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0060, 16'h0);
      chk("drop_last_rvalid", 32'(obs_r0_rv), 32'd1);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0060, 16'h0);
      chk("drop_owner", 32'(obs_owner), 32'd2);
      repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

`ifdef VGA_PRIORITY_EN
      // Loader mid-burst, VGA asserts: switch after the current beat, loader starved
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0070, 16'h0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0070, 16'h0);
      step(1'b1, 16'h0071, 1'b1, 1'b0, 16'h0070, 16'h0);
      chk("prio_cur_owner", 32'(obs_owner), 32'd2);
      repeat (6) begin
         step(1'b1, 16'h0071, 1'b1, 1'b0, 16'h0070, 16'h0);
         chk("prio_owner", 32'(obs_owner), 32'd1);
      end
      repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
`endif

      // Randomized traffic with occasional asynchronous reset
      rv0 = 1'b0;
      rv1 = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            mid_reset();
         end else begin
            if ($urandom_range(0, 3) == 0) rv0 = ~rv0;
            if ($urandom_range(0, 3) == 0) rv1 = ~rv1;
            ra0 = 16'($urandom_range(0, 255));
            ra1 = 16'($urandom_range(0, 255));
            rwd = 16'($urandom);
            rwe = 1'($urandom_range(0, 1));
            step(rv0, ra0, rv1, rwe, ra1, rwd);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
